decrypt_iter_128a: RTL and testbench

- Round-iterative Ascon-128a authenticated decryptor. It is the receive-side counterpart of the 128a encryption core.
- Takes key, nonce, one 128-bit associated-data block, one 128-bit ciphertext block and a 128-bit tag.
- Runs one Ascon round per clock and returns the plaintext plus a tag-verification flag.
- Plaintext is released only when the tag verifies; otherwise P is forced to zero.

---
 rtl/decrypt_iter_128a_if.sv | 23 ++
 rtl/decrypt_iter_128a.sv | 231 +++++++++++++++++++++++
 tb/tb_decrypt_iter_128a.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decrypt_iter_128a_if.sv
// Request/response bundle for the iterative Ascon-128a decryptor.
interface decrypt_iter_128a_if;
  logic         start;
  logic [127:0] SK;
  logic [127:0] N;
  logic [127:0] A;
  logic [127:0] C;
  logic [127:0] T;
  logic [127:0] P;
  logic         busy;
  logic         valid;
  logic         tag_ok;

  modport master (
    output start, SK, N, A, C, T,
    input  P, busy, valid, tag_ok
  );

  modport slave (
    input  start, SK, N, A, C, T,
    output P, busy, valid, tag_ok
  );
endinterface

// File: rtl/decrypt_iter_128a.sv
// Round-iterative Ascon-128a decryptor: one AD block, one ciphertext block,
// one permutation round per clock, fixed 49-cycle latency. Plaintext is only
// released once the full 128-bit tag has been verified.
module decrypt_iter_128a #(
  parameter logic [63:0] IV       = 64'h80800c0800000000,
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 8
) (
  input logic                  CLK,
  input logic                  RST,
  decrypt_iter_128a_if.slave   bus
);

  typedef logic [4:0][63:0] state_t;  // index w holds Ascon word Sw

  // CTPAD has no rounds of its own; its key addition is folded into CT's last cycle.
  typedef enum logic [2:0] {
    StIdle, StInit, StAd, StAdPad, StCt, StFinal, StCheck
  } st_e;

  localparam logic [3:0]  LastA = 4'(ROUNDS_A - 1);
  localparam logic [3:0]  LastB = 4'(ROUNDS_B - 1);
  localparam logic [63:0] Pad   = 64'h8000_0000_0000_0000;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
  function automatic state_t ascon_round(input state_t s, input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    state_t      r;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, rc};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    r[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    r[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    r[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    r[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return r;
  endfunction

  st_e          state_q, state_d;
  state_t       s_q, s_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] k_q, k_d;
  logic [127:0] a_q, a_d;
  logic [127:0] c_q, c_d;
  logic [127:0] t_q, t_d;
  logic [127:0] pint_q, pint_d;
  logic [127:0] tag_q, tag_d;
  logic [127:0] p_q, p_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         tag_ok_q, tag_ok_d;

  logic [3:0]   ridx;
  logic [7:0]   rc;
  state_t       rnd;
  logic         last;

  // Round constant index counts up while cnt counts the remaining rounds down.
  always_comb begin
    ridx = LastA - cnt_q;
    rc   = {4'hf - ridx, ridx};
    rnd  = ascon_round(s_q, rc);
    last = (cnt_q == 4'd0);
  end

  // Next-state and datapath decode for the phase sequencer.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    a_d      = a_q;
    c_d      = c_q;
    t_d      = t_q;
    pint_d   = pint_q;
    tag_d    = tag_q;
    p_d      = p_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    tag_ok_d = tag_ok_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          k_d      = bus.SK;
          a_d      = bus.A;
          c_d      = bus.C;
          t_d      = bus.T;
          s_d[0]   = IV;
          s_d[1]   = bus.SK[127:64];
          s_d[2]   = bus.SK[63:0];
          s_d[3]   = bus.N[127:64];
          s_d[4]   = bus.N[63:0];
          cnt_d    = LastA;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          p_d      = '0;
          tag_ok_d = 1'b0;
          state_d  = StInit;
        end
      end
      StInit: begin
        s_d   = rnd;
        cnt_d = cnt_q - 4'd1;
        if (last) begin
          s_d[3]  = rnd[3] ^ k_q[127:64];
          s_d[4]  = rnd[4] ^ k_q[63:0];
          s_d[0]  = rnd[0] ^ a_q[127:64];
          s_d[1]  = rnd[1] ^ a_q[63:0];
          cnt_d   = LastB;
          state_d = StAd;
        end
      end
      StAd: begin
        s_d   = rnd;
        cnt_d = cnt_q - 4'd1;
        if (last) begin
          s_d[0]  = rnd[0] ^ Pad;
          cnt_d   = LastB;
          state_d = StAdPad;
        end
      end
      StAdPad: begin
        s_d   = rnd;
        cnt_d = cnt_q - 4'd1;
        if (last) begin
          s_d[4]  = rnd[4] ^ 64'd1;
          pint_d  = {rnd[0], rnd[1]} ^ c_q;
          s_d[0]  = c_q[127:64];
          s_d[1]  = c_q[63:0];
          cnt_d   = LastB;
          state_d = StCt;
        end
      end
      StCt: begin
        s_d   = rnd;
        cnt_d = cnt_q - 4'd1;
        if (last) begin
          // Empty final block padding plus finalisation key addition.
          s_d[0]  = rnd[0] ^ Pad;
          s_d[2]  = rnd[2] ^ k_q[127:64];
          s_d[3]  = rnd[3] ^ k_q[63:0];
          cnt_d   = LastA;
          state_d = StFinal;
        end
      end
      StFinal: begin
        s_d   = rnd;
        cnt_d = cnt_q - 4'd1;
        if (last) begin
          tag_d   = {rnd[3] ^ k_q[127:64], rnd[4] ^ k_q[63:0]};
          cnt_d   = 4'd0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // Full-width compare, no early exit.
        tag_ok_d = (tag_q == t_q);
        p_d      = (tag_q == t_q) ? pint_q : '0;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset that aborts any operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      s_q      <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      a_q      <= '0;
      c_q      <= '0;
      t_q      <= '0;
      pint_q   <= '0;
      tag_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      tag_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      a_q      <= a_d;
      c_q      <= c_d;
      t_q      <= t_d;
      pint_q   <= pint_d;
      tag_q    <= tag_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      tag_ok_q <= tag_ok_d;
    end
  end

  assign bus.P      = p_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.tag_ok = tag_ok_q;

endmodule

// File: tb/tb_decrypt_iter_128a.sv
// Bench for decrypt_iter_128a: a table-based Ascon-128a encryption model
// produces C and T, the DUT must recover the plaintext with a fixed latency.
module tb_decrypt_iter_128a;

  localparam logic [63:0] MIV   = 64'h80800c0800000000;
  localparam logic [63:0] MPAD  = 64'h8000_0000_0000_0000;
  localparam logic [127:0] KSEQ = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef struct {
    logic [127:0] sk, n, a, c, t, p_exp;
    logic         ok_exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  decrypt_iter_128a_if bus ();

  decrypt_iter_128a dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference round using the S-box lookup table column by column.
  function automatic logic [319:0] m_round(input logic [319:0] s, input int i);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
    x[2] = x[2] ^ 64'((15 - i) * 16 + i);
    for (int b = 0; b < 64; b++) begin
      v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      v = SBOX[v];
      x[0][b] = v[4];
      x[1][b] = v[3];
      x[2][b] = v[2];
      x[3][b] = v[1];
      x[4][b] = v[0];
    end
    y[0] = x[0] ^ m_ror(x[0], 19) ^ m_ror(x[0], 28);
    y[1] = x[1] ^ m_ror(x[1], 61) ^ m_ror(x[1], 39);
    y[2] = x[2] ^ m_ror(x[2], 1)  ^ m_ror(x[2], 6);
    y[3] = x[3] ^ m_ror(x[3], 10) ^ m_ror(x[3], 17);
    y[4] = x[4] ^ m_ror(x[4], 7)  ^ m_ror(x[4], 41);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int rounds);
    logic [319:0] r;
    r = s;
    for (int i = 12 - rounds; i < 12; i++) r = m_round(r, i);
    return r;
  endfunction

  task automatic m_encrypt(input logic [127:0] k, input logic [127:0] n,
                           input logic [127:0] a, input logic [127:0] p,
                           output logic [127:0] c, output logic [127:0] t);
    logic [319:0] s;
    s = {MIV, k, n};
    s = m_perm(s, 12);
    s[127:0]   = s[127:0] ^ k;
    s[319:192] = s[319:192] ^ a;
    s = m_perm(s, 8);
    s[319:256] = s[319:256] ^ MPAD;
    s = m_perm(s, 8);
    s[0] = s[0] ^ 1'b1;
    c = s[319:192] ^ p;
    s[319:192] = c;
    s = m_perm(s, 8);
    s[319:256] = s[319:256] ^ MPAD;
    s[191:64]  = s[191:64] ^ k;
    s = m_perm(s, 12);
    t = s[127:0] ^ k;
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.SK = v.sk;
    bus.N  = v.n;
    bus.A  = v.a;
    bus.C  = v.c;
    bus.T  = v.t;
  endtask

  // Counts edges after the accepting edge until valid rises (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.valid && cyc < 60);
  endtask

  task automatic check_result(input vec_t v, input int cyc, input string nm);
    check({nm, " latency"}, 128'(cyc), 128'(49));
    check({nm, " P"}, bus.P, v.p_exp);
    check({nm, " tag_ok"}, 128'(bus.tag_ok), 128'(v.ok_exp));
    check({nm, " busy"}, 128'(bus.busy), 128'(0));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cyc;
    drive(v);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_valid(cyc);
    check_result(v, cyc, nm);
  endtask

  task automatic make_vec(input logic [127:0] sk, input logic [127:0] n,
                          input logic [127:0] a, input logic [127:0] p, output vec_t v);
    v.sk = sk;
    v.n  = n;
    v.a  = a;
    v.p_exp  = p;
    v.ok_exp = 1'b1;
    m_encrypt(sk, n, a, p, v.c, v.t);
  endtask

  vec_t vt [6];
  vec_t va, vb, junk;

  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.SK = '0;
    bus.N  = '0;
    bus.A  = '0;
    bus.C  = '0;
    bus.T  = '0;

    // Vector table: round trips and forgeries of the round-trip vector.
    make_vec(KSEQ, KSEQ, 128'h0, 128'h0, vt[0]);
    vt[1] = vt[0];
    vt[1].t[0] = ~vt[1].t[0];
    vt[1].p_exp = '0;
    vt[1].ok_exp = 1'b0;
    vt[2] = vt[0];
    vt[2].c[127] = ~vt[2].c[127];
    vt[2].p_exp = '0;
    vt[2].ok_exp = 1'b0;
    vt[3] = vt[0];
    vt[3].a[64] = ~vt[3].a[64];
    vt[3].p_exp = '0;
    vt[3].ok_exp = 1'b0;
    make_vec({128{1'b1}}, 128'h0, 128'hdeadbeef_cafef00d_01234567_89abcdef,
             128'h0123456789abcdef_fedcba9876543210, vt[4]);
    make_vec(128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0, 128'h1,
             128'h8000_0000_0000_0000_0000_0000_0000_0001, {128{1'b1}}, vt[5]);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 128'(bus.busy), 128'(0));
    check("reset valid", 128'(bus.valid), 128'(0));
    check("reset tag_ok", 128'(bus.tag_ok), 128'(0));
    check("reset P", bus.P, 128'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of an operation, then a clean run.
    drive(vt[4]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", 128'(bus.busy), 128'(0));
    check("midrst valid", 128'(bus.valid), 128'(0));
    check("midrst P", bus.P, 128'h0);
    rst = 1'b0;
    run_vec(vt[4], "after_rst");

    // start pulses while busy must be ignored.
    make_vec(KSEQ ^ 128'h77, KSEQ, 128'h42, 128'h99, junk);
    drive(vt[5]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 5 || cyc == 30) begin
        drive(junk);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.valid && cyc < 60);
    bus.start = 1'b0;
    check_result(vt[5], cyc, "busy_start");

    // Back-to-back with start held high.
    va = vt[4];
    vb = vt[0];
    drive(va);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    drive(vb);
    wait_valid(cyc);
    check_result(va, cyc, "b2b_first");
    @(posedge clk);
    #1;
    check("b2b accept valid", 128'(bus.valid), 128'(0));
    check("b2b accept busy", 128'(bus.busy), 128'(1));
    wait_valid(cyc);
    bus.start = 1'b0;
    check_result(vb, cyc, "b2b_second");

    // Random round trips.
    for (int r = 0; r < 500; r++) begin
      logic [127:0] rk, rn, ra, rp;
      vec_t rv;
      rk = {$urandom, $urandom, $urandom, $urandom};
      rn = {$urandom, $urandom, $urandom, $urandom};
      ra = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      make_vec(rk, rn, ra, rp, rv);
      run_vec(rv, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
